// File: rtl/counter_pkg.sv
// Shared constants for the stopwatch counter path: FSM encodings and
// default rates/terminal value used by the display chain.
package counter_pkg;

    localparam logic [1:0] ST_STOP  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_CLEAR = 2'b10;

    localparam int unsigned DEF_CLK_HZ    = 100_000_000;
    localparam int unsigned DEF_TICK_HZ   = 10;
    localparam int unsigned DEF_MAX_COUNT = 9999;

endpackage : counter_pkg

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles; the phase
// restarts from zero whenever enable drops.
module tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic o_tick
);

    localparam int unsigned      PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0]  LAST = PS_W'(DIV - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    always_comb begin
        ps_d = '0;
        if (enable) begin
            ps_d = (ps_q == LAST) ? '0 : ps_q + PS_W'(1);
        end
    end

    assign o_tick = enable && (ps_q == LAST);

endmodule : tick_gen

// File: rtl/updown_counter_param.sv
// Run/stop/clear up-down counter with configurable modulus, tick-enable
// stepping, load while stopped and a registered wrap pulse.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter  int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter  int unsigned TICK_HZ   = DEF_TICK_HZ,
    parameter  int unsigned MAX_COUNT = DEF_MAX_COUNT,
    localparam int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_clear,
    input  logic             i_updown,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_count,
    output logic             o_run,
    output logic             o_tick,
    output logic             o_wrap
);

    localparam int unsigned      DIV     = CLK_HZ / TICK_HZ;
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);

    logic [1:0]       state_q, state_d;
    logic             run_prev_q, clr_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             run_rise, clr_rise;
    logic             tick;

    assign run_rise = i_run & ~run_prev_q;
    assign clr_rise = i_clear & ~clr_prev_q;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == ST_RUN),
        .o_tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_STOP;
            run_prev_q <= 1'b0;
            clr_prev_q <= 1'b0;
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_prev_q <= i_run;
            clr_prev_q <= i_clear;
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
        end
    end

    // Next state: a clear edge always wins over a coincident run edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (clr_rise)      state_d = ST_CLEAR;
                else if (run_rise) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (clr_rise)      state_d = ST_CLEAR;
                else if (run_rise) state_d = ST_STOP;
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Count update: clear, tick step with wrap, or saturating load in STOP.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (state_q == ST_CLEAR) begin
            cnt_d = '0;
        end else if (tick) begin
            if (i_updown) begin
                if (cnt_q == MAX_VAL) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d  = MAX_VAL;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end else if ((state_q == ST_STOP) && i_load) begin
            cnt_d = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;
        end
    end

    assign o_count = cnt_q;
    assign o_run   = (state_q == ST_RUN);
    assign o_tick  = tick;
    assign o_wrap  = wrap_q;

endmodule : updown_counter_param

// File: tb/tb_updown_counter_param.sv
// Randomised and directed bench for updown_counter_param against a
// behavioural model of the run/clear/load/count rules.
module tb_updown_counter_param;

    localparam int DIV   = 10;
    localparam int MAXC  = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_run = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_updown = 1'b1;
    logic       i_load = 1'b0;
    logic [3:0] i_load_val = 4'd0;
    logic [3:0] o_count;
    logic       o_run;
    logic       o_tick;
    logic       o_wrap;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 = stopped, 1 = running, 2 = clearing
    int m_mode, m_count, m_phase, m_wrap;
    int m_prev_run, m_prev_clr;

    updown_counter_param #(
        .CLK_HZ    (100),
        .TICK_HZ   (10),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_run      (i_run),
        .i_clear    (i_clear),
        .i_updown   (i_updown),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .o_count    (o_count),
        .o_run      (o_run),
        .o_tick     (o_tick),
        .o_wrap     (o_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_count    = 0;
        m_phase    = 0;
        m_wrap     = 0;
        m_prev_run = 0;
        m_prev_clr = 0;
    endtask

    // Compare current outputs, then advance the model with the current inputs.
    task automatic model_step();
        int  nxt_mode;
        int  rise_r, rise_c;
        int  tick;
        tick = (m_mode == 1 && m_phase == DIV - 1) ? 1 : 0;
        check("count", int'(o_count), m_count);
        check("run",   int'(o_run),   (m_mode == 1) ? 1 : 0);
        check("tick",  int'(o_tick),  tick);
        check("wrap",  int'(o_wrap),  m_wrap);

        rise_r = (i_run   && !m_prev_run) ? 1 : 0;
        rise_c = (i_clear && !m_prev_clr) ? 1 : 0;

        m_wrap = 0;
        if (m_mode == 2) begin
            m_count = 0;
        end else if (tick == 1) begin
            if (i_updown) begin
                m_wrap  = (m_count == MAXC) ? 1 : 0;
                m_count = (m_count + 1) % (MAXC + 1);
            end else begin
                m_wrap  = (m_count == 0) ? 1 : 0;
                m_count = (m_count + MAXC) % (MAXC + 1);
            end
        end else if (m_mode == 0 && i_load) begin
            m_count = (int'(i_load_val) > MAXC) ? MAXC : int'(i_load_val);
        end

        m_phase = (m_mode == 1) ? (m_phase + 1) % DIV : 0;

        if (m_mode == 2)      nxt_mode = 0;
        else if (rise_c == 1) nxt_mode = 2;
        else if (rise_r == 1) nxt_mode = (m_mode == 1) ? 0 : 1;
        else                  nxt_mode = m_mode;
        m_mode = nxt_mode;

        m_prev_run = int'(i_run);
        m_prev_clr = int'(i_clear);
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input string tag, input int cnt, input int phase);
        int n = 0;
        while (!(m_mode == 1 && m_count == cnt && m_phase == phase) && n < 500) begin
            cycle();
            n++;
        end
        check(tag, int'(o_count), cnt);
    endtask

    // Asynchronous reset between edges; outputs must drop before any clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_count", int'(o_count), 0);
        check("rst_run",   int'(o_run),   0);
        check("rst_tick",  int'(o_tick),  0);
        check("rst_wrap",  int'(o_wrap),  0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_count", int'(o_count), 0);
        check("init_run",   int'(o_run),   0);
        check("init_tick",  int'(o_tick),  0);
        check("init_wrap",  int'(o_wrap),  0);
        reset = 1'b0;

        // Start counting up and check the wrap 9 -> 0
        i_run = 1'b1;
        cycle();
        i_run = 1'b0;
        check("run_start", int'(o_run), 1);
        run_until("reach9", 9, 0);
        run_until("wrap_up", 0, 0);
        check("wrap_up_pulse", int'(o_wrap), 1);
        cycle();
        check("wrap_up_once", int'(o_wrap), 0);

        // Down mode wraps 0 -> 9
        i_updown = 1'b0;
        run_until("wrap_dn", 9, 0);
        check("wrap_dn_pulse", int'(o_wrap), 1);

        // Simultaneous run and clear edges at count 5: clear wins
        i_updown = 1'b1;
        run_until("reach5", 5, 2);
        i_run   = 1'b1;
        i_clear = 1'b1;
        cycle();
        i_run   = 1'b0;
        i_clear = 1'b0;
        check("clr_run_low", int'(o_run), 0);
        check("clr_hold", int'(o_count), 5);
        cycle();
        check("clr_zero", int'(o_count), 0);
        check("clr_stop", int'(o_run), 0);
        repeat (3) cycle();

        // Saturating load in STOP, ignored load in RUN
        i_load     = 1'b1;
        i_load_val = 4'd12;
        cycle();
        i_load = 1'b0;
        check("load_sat", int'(o_count), 9);
        i_run = 1'b1;
        cycle();
        i_run = 1'b0;
        cycle();
        i_load     = 1'b1;
        i_load_val = 4'd3;
        cycle();
        i_load = 1'b0;
        check("load_in_run", int'(o_count), 9);

        // Direction change between ticks takes effect at the next tick
        run_until("reach4", 4, 5);
        i_updown = 1'b0;
        repeat (3) cycle();
        check("dir_hold", int'(o_count), 4);
        run_until("dir_step", 3, 0);

        // Reset mid-period, then i_run held high across release
        i_updown = 1'b1;
        run_until("reach7", 7, 3);
        i_run = 1'b1;
        async_reset();
        cycle();
        check("rerun", int'(o_run), 1);
        repeat (5) cycle();
        check("rerun_held", int'(o_run), 1);
        i_run = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                if ($urandom_range(0, 7) == 0) i_run = ~i_run;
                i_clear    = ($urandom_range(0, 59) == 0);
                i_load     = ($urandom_range(0, 3) == 0);
                i_load_val = 4'($urandom_range(0, 15));
                i_updown   = 1'($urandom_range(0, 1));
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_updown_counter_param

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised single-clock up/down counter core, the successor to the fixed 0–9999 stopwatch counter. It replaces the derived 10 Hz clock with a one-cycle tick enable in the `clk` domain. It adds a configurable modulus, edge-triggered run toggle and clear, synchronous load while stopped, and a wrap pulse. It sits between the button front end (already synchronised and debounced) and the FND display controller, which consumes `o_count`.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TICK_HZ`, 10, count rate; `DIV = CLK_HZ/TICK_HZ` (derived localparam, must be ≥ 2).
- `MAX_COUNT`, 9999, terminal value (≥ 1); `CNT_W = $clog2(MAX_COUNT+1)` (derived localparam).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `i_run`  in  1  run/stop button, level; acts on rising edge.
- `i_clear`  in  1  clear button, level; acts on rising edge.
- `i_updown`  in  1  1 = count up, 0 = count down; sampled only on tick cycles.
- `i_load`  in  1  load strobe, level; honoured only in STOP.
- `i_load_val`  in  CNT_W  load value.
- `o_count`  out  CNT_W  current count, 0..MAX_COUNT.
- `o_run`  out  1  high while state is RUN.
- `o_tick`  out  1  one-cycle pulse on each count step.
- `o_wrap`  out  1  one-cycle pulse when the count wraps.

## Operation
- Edge detect: `run_d` and `clr_d` hold the previous values of `i_run` and `i_clear`.
  - Both reset to 0, so an input held high at reset release produces one rising edge.
  - `run_rise = i_run & ~run_d`; `clr_rise = i_clear & ~clr_d`.
- FSM states STOP, RUN, CLEAR:
  - STOP: on `clr_rise` go to CLEAR; else on `run_rise` go to RUN; else stay.
  - RUN: on `clr_rise` go to CLEAR; else on `run_rise` go to STOP; else stay.
  - CLEAR: lasts exactly one cycle, then STOP unconditionally.
  - Clear always beats run. A run edge that coincides with a clear edge is discarded.
- Counter:
  - In CLEAR: `o_count` becomes 0.
  - In RUN with a tick, up: MAX_COUNT→0 with wrap, otherwise +1.
  - In RUN with a tick, down: 0→MAX_COUNT with wrap, otherwise −1.
  - In STOP with `i_load`: `o_count` becomes `min(i_load_val, MAX_COUNT)`.
  - `i_load` outside STOP is ignored.
- Prescaler: counts 0..DIV−1 only in RUN. It is held at 0 in STOP and CLEAR, so each RUN entry restarts the phase.
- Reset values: state STOP, `o_count` 0, `o_run` 0, `o_tick` 0, `o_wrap` 0, prescaler 0, `run_d`/`clr_d` 0.
- Reset mid-operation returns every register to its reset value immediately, with no partial step.

## Timing
- `o_run` is Moore (decoded from registered state). It rises one cycle after the cycle in which `run_rise` is sampled.
- `o_tick` is combinational: `(state==RUN) && (prescaler==DIV−1)`.
  - The first tick occurs DIV cycles after entering RUN, then every DIV cycles.
- `o_count` takes its new value at the clock edge that ends the `o_tick` cycle. The new value is visible one cycle after `o_tick`.
- `o_wrap` is registered and high in the same cycle as the wrapped `o_count` value, for one cycle.
- Clear: `o_count` reads 0 one cycle after entering CLEAR; `o_run` is low during CLEAR.
- Load: the value is visible one cycle after `i_load` is sampled in STOP.
- A change of `i_updown` between ticks has no effect until the next tick.

## Structure
- Shared package `counter_pkg`:
  - state encodings STOP=2'b00, RUN=2'b01, CLEAR=2'b10;
  - default `CLK_HZ`, `TICK_HZ`, `MAX_COUNT` constants for the display path.
- One natural sub-module: `tick_gen`.
  - Parameter DIV; inputs `clk`, `reset`, `enable`; output `o_tick`.
  - Contains the prescaler; it clears the prescaler when `enable` is low.
- The FSM, edge detect and counter live in the top module.

## Test plan
Bench parameters: CLK_HZ=100, TICK_HZ=10 (DIV=10), MAX_COUNT=9.
- Reset then an `i_run` pulse → `o_run`=1 next cycle; `o_tick` pulses every 10 cycles; `o_count` steps 0→1→…→9.
- Up mode at 9 plus a tick → `o_count`=0 and `o_wrap`=1 for exactly one cycle. Down mode at 0 plus a tick → `o_count`=9 and `o_wrap`=1.
- `i_run` and `i_clear` rise in the same cycle while in RUN at count 5 → CLEAR for one cycle, `o_count`=0, then STOP with `o_run`=0.
- In STOP, `i_load`=1 with `i_load_val`=12 → `o_count`=9 (saturated). In RUN, `i_load` with 3 → count unaffected.
- Toggle `i_updown` mid-period in RUN at count 4 → next tick gives 3, with no step between ticks.
- Assert `reset` mid-RUN at count 7, 3 cycles into the period → all outputs 0 asynchronously. After release, `i_run` held high gives one rising edge and RUN.
